pc_fetch_control: RTL and testbench

Program-counter and fetch-sequencing stage directly upstream of the instruction ROM. Holds the architectural 16-bit PC, computes the next PC from sequential, branch, jump and jump-register requests, and drives the ROM address each cycle. A small run/halt state machine gates fetching. A retired-instruction counter is provided for bring-up and debug.

---
 rtl/pc_fetch_control.sv | 99 +++++++++
 tb/tb_pc_fetch_control.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_control.sv
// Program-counter and fetch sequencer feeding the instruction ROM address.
// Run/halt FSM gates fetching; a saturating counter tracks retired instructions.
module pc_fetch_control #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_LIMIT = 16'd32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [6:0]  branch_imm,
    input  logic        jump,
    input  logic [12:0] jump_addr,
    input  logic        jr,
    input  logic [15:0] jr_addr,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        fetch_valid,
    output logic        halted,
    output logic [15:0] retired_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_retired;

    logic [15:0] w_pc_plus2;
    logic [15:0] w_branch_tgt;
    logic [15:0] w_jump_tgt;
    logic [15:0] w_jr_tgt;
    logic [15:0] w_next_pc;
    logic        w_advance;
    logic        w_limit_hit;
    logic        w_unused_jr_lsb;

    assign w_pc_plus2      = r_pc + 16'd2;
    assign w_branch_tgt    = w_pc_plus2 + {{8{branch_imm[6]}}, branch_imm, 1'b0};
    assign w_jump_tgt      = {w_pc_plus2[15:14], jump_addr, 1'b0};
    assign w_jr_tgt        = {jr_addr[15:1], 1'b0};
    assign w_unused_jr_lsb = jr_addr[0];

    always_comb begin
        w_next_pc = w_pc_plus2;
        if (jr)
            w_next_pc = w_jr_tgt;
        else if (jump)
            w_next_pc = w_jump_tgt;
        else if (branch_taken)
            w_next_pc = w_branch_tgt;
    end

    // Limit test is on the wrapped 16-bit result, so wrap-around also halts.
    assign w_advance   = (r_state == ST_RUN) && !stall;
    assign w_limit_hit = (w_next_pc >= PC_LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_advance && w_limit_hit) w_state_nxt = ST_HALT;
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pc <= RESET_PC;
        else if (w_advance && !w_limit_hit)
            r_pc <= w_next_pc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_retired <= '0;
        else if (w_advance && (r_retired != '1))
            r_retired <= r_retired + 16'd1;
    end

    assign pc            = r_pc;
    assign pc_plus2      = w_pc_plus2;
    assign fetch_valid   = (r_state == ST_RUN);
    assign halted        = (r_state == ST_HALT);
    assign retired_count = r_retired;

endmodule

// File: tb/tb_pc_fetch_control.sv
// Scoreboard bench for pc_fetch_control: driver pushes model expectations per cycle,
// monitor pops and compares after each rising edge.
module tb_pc_fetch_control;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [6:0]  branch_imm = '0;
    logic        jump = 1'b0;
    logic [12:0] jump_addr = '0;
    logic        jr = 1'b0;
    logic [15:0] jr_addr = '0;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        fetch_valid;
    logic        halted;
    logic [15:0] retired_count;

    pc_fetch_control #(.RESET_PC(16'h0000), .PC_LIMIT(16'd32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jump(jump), .jump_addr(jump_addr), .jr(jr), .jr_addr(jr_addr),
        .pc(pc), .pc_plus2(pc_plus2), .fetch_valid(fetch_valid),
        .halted(halted), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] rc;
        logic        fv;
        logic        h;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done = 1'b0;

    // Reference model: mode 0 = idle, 1 = running, 2 = halted
    int m_mode = 0;
    int m_pc = 0;
    int m_rc = 0;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic exp_t model_snapshot();
        exp_t e;
        e.pc = m_pc[15:0];
        e.rc = m_rc[15:0];
        e.fv = (m_mode == 1);
        e.h  = (m_mode == 2);
        return e;
    endfunction

    function automatic void model_step(bit st, bit sl, bit bt, int imm, bit j, int ja,
                                       bit r, int ra);
        int np;
        int immv;
        if (m_mode == 0) begin
            if (st) m_mode = 1;
        end else if (m_mode == 1 && !sl) begin
            immv = (imm >= 64) ? imm - 128 : imm;
            if (r)       np = ra & 'hFFFE;
            else if (j)  np = ((m_pc + 2) & 'hC000) | (ja * 2);
            else if (bt) np = (m_pc + 2 + 2 * immv) & 'hFFFF;
            else         np = (m_pc + 2) & 'hFFFF;
            if (m_rc < 65535) m_rc++;
            if (np < 32) m_pc = np;
            else         m_mode = 2;
        end
    endfunction

    task automatic cycle(bit st, bit sl, bit bt, int imm, bit j, int ja, bit r, int ra);
        @(negedge clk);
        start = st; stall = sl; branch_taken = bt; branch_imm = imm[6:0];
        jump = j; jump_addr = ja[12:0]; jr = r; jr_addr = ra[15:0];
        model_step(st, sl, bt, imm, j, ja, r, ra);
        exp_q.push_back(model_snapshot());
    endtask

    task automatic seq(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Assert reset between edges, check the asynchronous values, release on a falling edge
    task automatic do_reset();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        m_mode = 0; m_pc = 0; m_rc = 0;
        check("rst_pc", pc, 0);
        check("rst_pc_plus2", pc_plus2, 2);
        check("rst_retired", retired_count, 0);
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_halted", halted, 0);
        @(negedge clk);
        start = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("pc_plus2", pc_plus2, (e.pc + 16'd2));
                check("retired_count", retired_count, e.rc);
                check("fetch_valid", fetch_valid, e.fv);
                check("halted", halted, e.h);
            end
        end
    end

    initial begin : driver
        do_reset();
        // free-running from start
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        seq(5);

        // branch backward then forward
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        seq(2);
        cycle(0, 0, 1, 'h7E, 0, 0, 0, 0);
        cycle(0, 0, 1, 'h03, 0, 0, 0, 0);

        // jr priority, jump, run to limit, frozen halt
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        seq(3);
        cycle(0, 0, 1, 5, 1, 3, 1, 'h0015);
        cycle(0, 0, 0, 0, 1, 'h0008, 0, 0);
        seq(8);
        for (int i = 0; i < 10; i++)
            cycle(i % 2, (i / 2) % 2, 1, 2, 1, 4, 0, 0);

        // stall hold, release, asynchronous reset mid-run
        do_reset();
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        seq(4);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 3, 1, 2, 1, 4);
        seq(2);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 1, 1, 1, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        seq(1);

        // randomized episodes
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                int rnd;
                rnd = $urandom_range(0, 99);
                cycle(($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 4) == 0),
                      (rnd < 20),
                      $urandom_range(0, 127),
                      (rnd >= 20 && rnd < 27) || ($urandom_range(0, 9) == 0),
                      (ep % 5 == 0) ? $urandom_range(0, 8191) : $urandom_range(0, 17),
                      (rnd >= 90),
                      (ep % 4 == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 35));
            end
        end

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        done = 1'b1;
    end

    initial begin : finisher
        fork
            wait (done);
            #200000;
        join_any
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: driver done=%0b, expected 1", done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
